// File: rtl/neuron_timestep_scheduler.sv
// Timestep sequencer for one neuron cluster: buffers input spike events, replays them
// one per cycle onto the shared source bus, then settles, captures spikes and clears.
module neuron_timestep_scheduler #(
  parameter int                ADDR_W        = 12,
  parameter int                NUM_NEURONS   = 8,
  parameter int                FIFO_DEPTH    = 16,
  parameter int                SETTLE_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IDLE_ADDR     = {ADDR_W{1'b1}}
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   start,
  input  logic [15:0]            num_timesteps,
  input  logic                   evt_valid,
  input  logic [ADDR_W-1:0]      evt_addr,
  output logic                   evt_ready,
  input  logic                   ts_end,
  output logic [ADDR_W-1:0]      source_address,
  output logic                   src_valid,
  output logic                   neuron_clear,
  input  logic [NUM_NEURONS-1:0] neuron_spikes,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic                   spike_vec_valid,
  output logic [15:0]            timestep_count,
  output logic                   busy,
  output logic                   done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_SETTLE,
    S_CAPTURE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic              ts_pending;
  logic [SET_W-1:0]  settle_cnt;
  logic [15:0]       num_ts_reg;
  logic              last_ts;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign evt_ready  = !fifo_full && (state == S_IDLE || state == S_DISPATCH) && !ts_pending;
  assign push       = evt_valid && evt_ready;
  assign pop        = (state == S_DISPATCH) && !fifo_empty;
  assign busy       = (state != S_IDLE);
  assign last_ts    = ((timestep_count + 16'd1) == num_ts_reg);

  // Event FIFO bookkeeping; depth is a power of two so the pointers wrap on their own.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= evt_addr;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = (num_timesteps == 16'd0) ? S_DONE : S_DISPATCH;
      end
      S_DISPATCH: begin
        if (ts_pending && fifo_empty) state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt == '0) state_next = S_CAPTURE;
      end
      S_CAPTURE: state_next = S_CLEAR;
      S_CLEAR:   state_next = last_ts ? S_DONE : S_DISPATCH;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Run bookkeeping: an event accepted alongside ts_end still lands before the
  // pending flag blocks further pushes, so it stays in the current timestep.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ts_pending     <= 1'b0;
      settle_cnt     <= '0;
      num_ts_reg     <= '0;
      timestep_count <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        num_ts_reg     <= num_timesteps;
        timestep_count <= '0;
      end
      if (state == S_DISPATCH && ts_end) ts_pending <= 1'b1;
      if (state == S_DISPATCH && state_next == S_SETTLE)
        settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
      else if (state == S_SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - SET_W'(1);
      if (state == S_CLEAR) begin
        timestep_count <= timestep_count + 16'd1;
        ts_pending     <= 1'b0;
      end
    end
  end

  // Registered cluster-facing outputs; clear and spike strobe both land in the CLEAR cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      source_address  <= IDLE_ADDR;
      src_valid       <= 1'b0;
      neuron_clear    <= 1'b0;
      spike_vec       <= '0;
      spike_vec_valid <= 1'b0;
      done            <= 1'b0;
    end else begin
      src_valid       <= pop;
      source_address  <= pop ? fifo_mem[rd_ptr] : IDLE_ADDR;
      neuron_clear    <= (state == S_CAPTURE);
      spike_vec_valid <= (state == S_CAPTURE);
      if (state == S_CAPTURE) spike_vec <= neuron_spikes;
      done            <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_neuron_timestep_scheduler.sv
// Self-checking bench for neuron_timestep_scheduler: directed scenarios plus randomized
// runs compared against a queue-based model of events, spike captures and clears.
module tb_neuron_timestep_scheduler;

  localparam int          ADDR_W = 12;
  localparam int          NN     = 8;
  localparam int          DEPTH  = 16;
  localparam int          SETTLE = 2;
  localparam logic [11:0] IDLE_A = 12'hFFF;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   num_timesteps = '0;
  logic          evt_valid = 1'b0;
  logic [11:0]   evt_addr = '0;
  logic          evt_ready;
  logic          ts_end = 1'b0;
  logic [11:0]   source_address;
  logic          src_valid;
  logic          neuron_clear;
  logic [7:0]    neuron_spikes = '0;
  logic [7:0]    spike_vec;
  logic          spike_vec_valid;
  logic [15:0]   timestep_count;
  logic          busy;
  logic          done;

  int checks = 0;
  int fails  = 0;
  longint cyc = 0;

  logic [11:0] mon_addr[$];
  longint      mon_addr_t[$];
  logic [7:0]  mon_spk[$];
  longint      mon_spk_t[$];
  int mon_clear_n = 0, mon_done_n = 0, mon_overlap_n = 0, mon_bad_n = 0;

  neuron_timestep_scheduler #(
    .ADDR_W(ADDR_W), .NUM_NEURONS(NN), .FIFO_DEPTH(DEPTH),
    .SETTLE_CYCLES(SETTLE), .IDLE_ADDR(IDLE_A)
  ) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .num_timesteps(num_timesteps),
    .evt_valid(evt_valid), .evt_addr(evt_addr), .evt_ready(evt_ready),
    .ts_end(ts_end), .source_address(source_address), .src_valid(src_valid),
    .neuron_clear(neuron_clear), .neuron_spikes(neuron_spikes),
    .spike_vec(spike_vec), .spike_vec_valid(spike_vec_valid),
    .timestep_count(timestep_count), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Observe the cluster-facing side once per cycle, away from the active edge.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (src_valid) begin
        mon_addr.push_back(source_address);
        mon_addr_t.push_back(cyc);
        if (source_address == IDLE_A) mon_bad_n++;
      end else if (source_address !== IDLE_A) begin
        mon_bad_n++;
      end
      if (spike_vec_valid) begin
        mon_spk.push_back(spike_vec);
        mon_spk_t.push_back(cyc);
      end
      if (neuron_clear) mon_clear_n++;
      if (done) mon_done_n++;
      if (neuron_clear && src_valid) mon_overlap_n++;
    end
  end

  task automatic mon_reset();
    mon_addr.delete(); mon_addr_t.delete(); mon_spk.delete(); mon_spk_t.delete();
    mon_clear_n = 0; mon_done_n = 0; mon_overlap_n = 0; mon_bad_n = 0;
  endtask

  task automatic mon_flush();
    repeat (2) @(negedge CLK);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!evt_ready && n < 200) begin @(negedge CLK); n++; end
    ok = evt_ready;
  endtask

  task automatic push_event(input logic [11:0] a, output bit ok);
    evt_valid = 1'b1;
    evt_addr  = a;
    wait_ready(ok);
    if (ok) @(negedge CLK);
    evt_valid = 1'b0;
  endtask

  task automatic pulse_ts_end(output bit ok);
    wait_ready(ok);
    ts_end = 1'b1;
    @(negedge CLK);
    ts_end = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] n);
    num_timesteps = n;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_for_clear(output bit ok);
    int n = 0;
    while (!neuron_clear && n < 200) begin @(negedge CLK); n++; end
    ok = neuron_clear;
    @(negedge CLK);
  endtask

  task automatic wait_for_done(output bit ok);
    int n = 0;
    while (!done && n < 300) begin @(negedge CLK); n++; end
    ok = done;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [31:0] act[9];
    logic [31:0] exp[9];
    string nm[9];
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    nm[0] = "source_address"; act[0] = 32'(source_address); exp[0] = 32'(IDLE_A);
    nm[1] = "src_valid";      act[1] = 32'(src_valid);      exp[1] = 0;
    nm[2] = "neuron_clear";   act[2] = 32'(neuron_clear);   exp[2] = 0;
    nm[3] = "spike_vec";      act[3] = 32'(spike_vec);      exp[3] = 0;
    nm[4] = "spike_vec_valid";act[4] = 32'(spike_vec_valid);exp[4] = 0;
    nm[5] = "timestep_count"; act[5] = 32'(timestep_count); exp[5] = 0;
    nm[6] = "busy";           act[6] = 32'(busy);           exp[6] = 0;
    nm[7] = "done";           act[7] = 32'(done);           exp[7] = 0;
    nm[8] = "evt_ready";      act[8] = 32'(evt_ready);      exp[8] = 1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (act[i] !== exp[i]) begin
        fails++;
        $display("[TB] FAIL reset_%s: got %0h expected %0h", nm[i], act[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    logic [31:0] act[6];
    logic [31:0] exp[6];
    string nm[6];
    mon_reset();
    for (int i = 0; i < 5; i++) push_event(12'h010 + 12'(i), ok);
    pulse_start(16'd3);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    nm[0] = "source_address"; act[0] = 32'(source_address); exp[0] = 32'(IDLE_A);
    nm[1] = "src_valid";      act[1] = 32'(src_valid);      exp[1] = 0;
    nm[2] = "timestep_count"; act[2] = 32'(timestep_count); exp[2] = 0;
    nm[3] = "busy";           act[3] = 32'(busy);           exp[3] = 0;
    nm[4] = "done";           act[4] = 32'(done);           exp[4] = 0;
    nm[5] = "evt_ready";      act[5] = 32'(evt_ready);      exp[5] = 1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (act[i] !== exp[i]) begin
        fails++;
        $display("[TB] FAIL midrun_reset_%s: got %0h expected %0h", nm[i], act[i], exp[i]);
      end
    end
    pulse_start(16'd1);
    repeat (8) @(negedge CLK);
    #1;
    checks++;
    if (mon_addr.size() !== 0) begin
      fails++;
      $display("[TB] FAIL fifo_flushed: got %0d dispatched expected 0", mon_addr.size());
    end
    checks++;
    if (mon_done_n !== 0) begin
      fails++;
      $display("[TB] FAIL aborted_no_done: got %0d done pulses expected 0", mon_done_n);
    end
    pulse_ts_end(ok);
    wait_for_done(ok);
    mon_flush();
    checks++;
    if (!ok || mon_done_n !== 1 || mon_clear_n !== 1) begin
      fails++;
      $display("[TB] FAIL restart_run: got done=%0d clears=%0d expected 1 and 1", mon_done_n, mon_clear_n);
    end
  endtask

  task automatic test_basic();
    bit ok;
    mon_reset();
    neuron_spikes = 8'hA5;
    pulse_start(16'd2);
    push_event(12'h001, ok);
    push_event(12'h002, ok);
    pulse_ts_end(ok);
    wait_for_clear(ok);
    push_event(12'h003, ok);
    pulse_ts_end(ok);
    wait_for_done(ok);
    mon_flush();
    checks++;
    if (mon_addr.size() != 3 || mon_addr[0] !== 12'h001 || mon_addr[1] !== 12'h002 || mon_addr[2] !== 12'h003) begin
      fails++;
      $display("[TB] FAIL basic_order: got %0d events %p expected 001 002 003", mon_addr.size(), mon_addr);
    end
    checks++;
    if (mon_addr_t.size() < 2 || (mon_addr_t[1] - mon_addr_t[0]) != 1) begin
      fails++;
      $display("[TB] FAIL basic_consecutive: got stamps %p expected consecutive", mon_addr_t);
    end
    checks++;
    if (mon_spk.size() != 2 || mon_spk[0] !== 8'hA5 || mon_spk[1] !== 8'hA5) begin
      fails++;
      $display("[TB] FAIL basic_spikes: got %p expected two A5", mon_spk);
    end
    checks++;
    if (mon_clear_n !== 2) begin
      fails++;
      $display("[TB] FAIL basic_clears: got %0d expected 2", mon_clear_n);
    end
    checks++;
    if (timestep_count !== 16'd2) begin
      fails++;
      $display("[TB] FAIL basic_count: got %0d expected 2", timestep_count);
    end
    checks++;
    if (mon_done_n !== 1) begin
      fails++;
      $display("[TB] FAIL basic_done: got %0d expected 1", mon_done_n);
    end
  endtask

  task automatic test_fifo_full();
    bit ok;
    bit all_ok = 1'b1;
    int gaps = 0;
    int order_err = 0;
    mon_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push_event(12'h100 + 12'(i), ok);
      all_ok &= ok;
    end
    checks++;
    if (!all_ok || evt_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL full_ready: got ready=%0b accepted_all=%0b expected ready 0", evt_ready, all_ok);
    end
    pulse_start(16'd1);
    pulse_ts_end(ok);
    wait_for_done(ok);
    mon_flush();
    for (int i = 0; i < mon_addr.size(); i++) begin
      if (mon_addr[i] !== 12'h100 + 12'(i)) order_err++;
      if (i > 0 && (mon_addr_t[i] - mon_addr_t[i-1]) != 1) gaps++;
    end
    checks++;
    if (mon_addr.size() != DEPTH || order_err != 0) begin
      fails++;
      $display("[TB] FAIL full_order: got %0d events (%0d misordered) expected %0d in order", mon_addr.size(), order_err, DEPTH);
    end
    checks++;
    if (gaps != 0) begin
      fails++;
      $display("[TB] FAIL full_back_to_back: got %0d gaps expected 0", gaps);
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    int n = 0;
    int ready_bad = 0;
    mon_reset();
    pulse_start(16'd1);
    wait_ready(ok);
    evt_valid = 1'b1; evt_addr = 12'h0AA; ts_end = 1'b1;
    @(negedge CLK);
    evt_valid = 1'b0; ts_end = 1'b0;
    while (!neuron_clear && n < 50) begin
      if (evt_ready) ready_bad++;
      @(negedge CLK);
      n++;
    end
    if (evt_ready) ready_bad++;
    wait_for_done(ok);
    mon_flush();
    checks++;
    if (mon_addr.size() != 1 || mon_addr[0] !== 12'h0AA) begin
      fails++;
      $display("[TB] FAIL same_cycle_event: got %p expected 0AA", mon_addr);
    end
    checks++;
    if (mon_addr_t.size() != 1 || mon_spk_t.size() != 1 || (mon_spk_t[0] - mon_addr_t[0]) != SETTLE + 2) begin
      fails++;
      $display("[TB] FAIL same_cycle_timing: got addr@%p spikes@%p expected gap %0d", mon_addr_t, mon_spk_t, SETTLE + 2);
    end
    checks++;
    if (ready_bad != 0 || n >= 50) begin
      fails++;
      $display("[TB] FAIL same_cycle_ready: got %0d ready cycles (wait %0d) expected 0", ready_bad, n);
    end
  endtask

  task automatic test_zero_timesteps();
    bit d1, d2, d3, b2;
    mon_reset();
    pulse_start(16'd0);
    d1 = done;
    @(negedge CLK);
    d2 = done; b2 = busy;
    @(negedge CLK);
    d3 = done;
    mon_flush();
    checks++;
    if (d1 !== 1'b0 || d2 !== 1'b1 || d3 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_done_timing: got %0b%0b%0b expected 010", d1, d2, d3);
    end
    checks++;
    if (b2 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_busy: got %0b expected 0", b2);
    end
    checks++;
    if (mon_clear_n !== 0 || mon_spk.size() != 0 || mon_done_n !== 1) begin
      fails++;
      $display("[TB] FAIL zero_side_effects: got clears=%0d strobes=%0d done=%0d expected 0 0 1", mon_clear_n, mon_spk.size(), mon_done_n);
    end
  endtask

  task automatic test_empty_timestep();
    bit ok;
    int n = 1;
    bit clr_at_strobe;
    mon_reset();
    neuron_spikes = 8'h3C;
    pulse_start(16'd1);
    wait_ready(ok);
    ts_end = 1'b1;
    @(negedge CLK);
    ts_end = 1'b0;
    while (!spike_vec_valid && n < 50) begin @(negedge CLK); n++; end
    clr_at_strobe = neuron_clear;
    wait_for_done(ok);
    mon_flush();
    checks++;
    if (n != SETTLE + 3) begin
      fails++;
      $display("[TB] FAIL empty_ts_latency: got %0d cycles expected %0d", n, SETTLE + 3);
    end
    checks++;
    if (clr_at_strobe !== 1'b1 || mon_clear_n !== 1) begin
      fails++;
      $display("[TB] FAIL empty_ts_clear: got clr=%0b clears=%0d expected 1 1", clr_at_strobe, mon_clear_n);
    end
    checks++;
    if (mon_addr.size() != 0 || mon_spk.size() != 1 || mon_spk[0] !== 8'h3C) begin
      fails++;
      $display("[TB] FAIL empty_ts_bus: got events=%0d spikes=%p expected 0 and 3C", mon_addr.size(), mon_spk);
    end
  endtask

  task automatic test_random_runs();
    bit ok;
    for (int r = 0; r < 4; r++) begin
      logic [11:0] exp_addr[$];
      logic [7:0]  exp_spk[$];
      int num = $urandom_range(1, 4);
      int pre = $urandom_range(0, 3);
      int addr_err = 0;
      int spk_err = 0;
      int to = 0;
      mon_reset();
      for (int i = 0; i < pre; i++) begin
        logic [11:0] a = 12'($urandom_range(0, 12'hFFE));
        exp_addr.push_back(a);
        push_event(a, ok);
        if (!ok) to++;
      end
      pulse_start(16'(num));
      for (int t = 0; t < num; t++) begin
        int cnt = $urandom_range(0, 5);
        logic [7:0] s = 8'($urandom);
        for (int i = 0; i < cnt; i++) begin
          logic [11:0] a = 12'($urandom_range(0, 12'hFFE));
          exp_addr.push_back(a);
          push_event(a, ok);
          if (!ok) to++;
        end
        neuron_spikes = s;
        exp_spk.push_back(s);
        pulse_ts_end(ok);
        if (!ok) to++;
        if (t < num - 1) wait_for_clear(ok);
        else             wait_for_done(ok);
        if (!ok) to++;
      end
      mon_flush();
      for (int i = 0; i < exp_addr.size() && i < mon_addr.size(); i++)
        if (mon_addr[i] !== exp_addr[i]) addr_err++;
      for (int i = 0; i < exp_spk.size() && i < mon_spk.size(); i++)
        if (mon_spk[i] !== exp_spk[i]) spk_err++;
      checks++;
      if (to != 0) begin
        fails++;
        $display("[TB] FAIL rand%0d_timeout: got %0d expired waits expected 0", r, to);
      end
      checks++;
      if (mon_addr.size() != exp_addr.size() || addr_err != 0) begin
        fails++;
        $display("[TB] FAIL rand%0d_events: got %0d (%0d wrong) expected %0d", r, mon_addr.size(), addr_err, exp_addr.size());
      end
      checks++;
      if (mon_spk.size() != exp_spk.size() || spk_err != 0) begin
        fails++;
        $display("[TB] FAIL rand%0d_spikes: got %0d (%0d wrong) expected %0d", r, mon_spk.size(), spk_err, exp_spk.size());
      end
      checks++;
      if (mon_clear_n != num || timestep_count !== 16'(num) || mon_done_n != 1) begin
        fails++;
        $display("[TB] FAIL rand%0d_counts: got clears=%0d count=%0d done=%0d expected %0d %0d 1", r, mon_clear_n, timestep_count, mon_done_n, num, num);
      end
      checks++;
      if (mon_overlap_n != 0 || mon_bad_n != 0) begin
        fails++;
        $display("[TB] FAIL rand%0d_bus: got overlap=%0d bad_idle=%0d expected 0 0", r, mon_overlap_n, mon_bad_n);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_reset_midrun();
    test_basic();
    test_fifo_full();
    test_same_cycle();
    test_zero_timesteps();
    test_empty_timestep();
    test_random_runs();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/neuron_timestep_scheduler.md
Name: neuron_timestep_scheduler

Overview:
Sequences one neuron cluster through a run of timesteps. Input spike events (source addresses) are buffered in an internal FIFO and replayed one per cycle onto the cluster's shared source_address bus. At each timestep boundary the block lets the potential pipeline settle, captures the cluster spike vector, then pulses the cluster clear. It sits between the event router/host and the neuron array.

Parameters:
ADDR_W, 12, width of source/event addresses
NUM_NEURONS, 8, width of neuron spike vector sampled per timestep
FIFO_DEPTH, 16, event FIFO entries (power of two)
SETTLE_CYCLES, 2, idle cycles between last dispatched event and spike capture (>=1)
IDLE_ADDR, 12'hFFF, address driven when no event is dispatched (never matches a real source)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
start  in  1  begin run (sampled in IDLE only)
num_timesteps  in  16  timesteps in run, sampled on accepted start
evt_valid  in  1  event valid
evt_addr  in  ADDR_W  event source address
evt_ready  out  1  event accepted when evt_valid&evt_ready
ts_end  in  1  pulse: no more events for current timestep
source_address  out  ADDR_W  address to neuron cluster (registered)
src_valid  out  1  source_address carries a real event this cycle
neuron_clear  out  1  one-cycle timestep clear to cluster
neuron_spikes  in  NUM_NEURONS  cluster spike outputs
spike_vec  out  NUM_NEURONS  captured spikes for finished timestep
spike_vec_valid  out  1  one-cycle strobe with spike_vec
timestep_count  out  16  completed timesteps in current run
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset (any state, incl. mid-run): state IDLE, FIFO flushed, ts_pending=0, source_address=IDLE_ADDR, src_valid=0, neuron_clear=0, spike_vec=0, spike_vec_valid=0, timestep_count=0, busy=0, done=0. Aborted run gives no done.
- evt_ready = !fifo_full && (state==IDLE || state==DISPATCH) && !ts_pending. IDLE accepts events, so the first timestep can be preloaded.
- FIFO: push on evt_valid&evt_ready; simultaneous push and pop keeps the count unchanged. Full blocks pushes via evt_ready. No overflow or underflow is possible.
- States: IDLE, DISPATCH, SETTLE, CAPTURE, CLEAR, DONE.
- IDLE: start=1 with num_timesteps>0 latches num_timesteps, clears timestep_count, and goes to DISPATCH. With num_timesteps==0 it goes to DONE. start outside IDLE is ignored.
- DISPATCH: if the FIFO is non-empty, pop one entry per cycle. The next edge registers source_address=entry and src_valid=1. Otherwise source_address=IDLE_ADDR and src_valid=0. Latency from accepting edge to bus is 1 cycle when the FIFO was empty.
- ts_end in DISPATCH sets ts_pending. An event accepted in the same cycle as ts_end belongs to the current timestep. ts_end in other states is ignored.
- DISPATCH exits to SETTLE when ts_pending && FIFO empty. The transition cycle drives IDLE_ADDR.
- SETTLE: drive IDLE_ADDR for SETTLE_CYCLES cycles (down-counter), then go to CAPTURE.
- CAPTURE (1 cycle): spike_vec<=neuron_spikes and spike_vec_valid=1 on the next cycle.
- CLEAR (1 cycle): neuron_clear=1, timestep_count+1, ts_pending cleared. If the new count == num_timesteps, go to DONE; else go to DISPATCH.
- DONE: done=1 for one cycle, then IDLE. timestep_count holds until the next start or reset.
- neuron_clear is never asserted in the same cycle as src_valid.
- Counters are 16-bit. num_timesteps=16'hFFFF must complete without wrap.

Test Plan:
1. RESET held 3 cycles mid-DISPATCH with 5 events queued -> all outputs at reset values, evt_ready=1 next cycle, no done, FIFO empty (no src_valid after restart without new events).
2. num_timesteps=2, events 0x001,0x002 then ts_end, then 0x003 then ts_end, neuron_spikes=8'hA5 -> source_address 0x001,0x002 on consecutive cycles, spike_vec=A5 strobed twice, two neuron_clear pulses, timestep_count=2, done once.
3. Push 16 events in IDLE -> evt_ready low on 17th. start -> 16 consecutive src_valid cycles in FIFO order.
4. evt_valid and ts_end in the same cycle (addr 0x0AA) -> 0x0AA dispatched before SETTLE. evt_ready=0 after that until CLEAR completes.
5. start with num_timesteps=0 -> done pulse 2 cycles later, no neuron_clear, no spike_vec_valid.
6. Empty timestep (ts_end only, SETTLE_CYCLES=2) -> exactly 2 IDLE_ADDR cycles, capture, clear, no src_valid.
